i2c_reg_target: RTL and testbench

I2C_REG_TARGET -- requirements
Module: i2c_reg_target

---
 rtl/i2c_reg_target.sv | 154 +++++++++++++++
 tb/tb_i2c_reg_target.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_target.sv
// rtl/i2c_reg_target.sv - I2C target exposing a byte register file behind a register pointer.
// Define I2C_TARGET_AUTO_INC_EN to advance the pointer after every data byte.
module i2c_reg_target #(
   parameter logic [6:0] DEV_ADDR = 7'h39,
   parameter int         REG_AW   = 4
) (
   input  logic              clk_ref,
   input  logic              reset_n,
   input  logic              i2c_scl,
   inout  wire               i2c_sda,
   output logic              wr_valid,
   output logic [REG_AW-1:0] wr_addr,
   output logic [7:0]        wr_data,
   input  logic [REG_AW-1:0] rd_addr,
   output logic [7:0]        rd_data,
   output logic              busy
);
   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
      S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT_STOP
   } state_t;

   state_t            state, state_nxt;
   logic [7:0]        regs [2**REG_AW];
   logic [REG_AW-1:0] ptr, ptr_adv;
   logic [7:0]        shreg, rx_byte;
   logic [3:0]        bit_cnt;
   logic              ack_drv, rw, nack, sda_low;
   logic              scl_s1, scl_s2, scl_d, sda_s1, sda_s2, sda_d;
   logic              scl_rise, scl_fall, start_det, stop_det, byte_done, addr_hit;

   always_ff @(posedge clk_ref or negedge reset_n) begin
      if (!reset_n) begin
         {scl_s1, scl_s2, scl_d} <= 3'b111;
         {sda_s1, sda_s2, sda_d} <= 3'b111;
      end else begin
         {scl_s1, scl_s2, scl_d} <= {i2c_scl, scl_s1, scl_s2};
         {sda_s1, sda_s2, sda_d} <= {i2c_sda, sda_s1, sda_s2};
      end
   end

   assign scl_rise  = scl_s2 & ~scl_d;
   assign scl_fall  = ~scl_s2 & scl_d;
   assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
   assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
   assign rx_byte   = {shreg[6:0], sda_s2};
   assign byte_done = scl_rise && (bit_cnt == 4'd7);
   assign addr_hit  = (rx_byte[7:1] == DEV_ADDR);

`ifdef I2C_TARGET_AUTO_INC_EN
   assign ptr_adv = ptr + 1'b1;
`else
   assign ptr_adv = ptr;
`endif

   // Open-drain: only ever pull low; the read shifter drives its MSB.
   assign sda_low = ack_drv | ((state == S_RDATA) & ~shreg[7]);
   assign i2c_sda = sda_low ? 1'b0 : 1'bz;
   assign rd_data = regs[rd_addr];

   always_ff @(posedge clk_ref or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (stop_det)       state_nxt = S_IDLE;
      else if (start_det) state_nxt = S_ADDR;
      else begin
         case (state)
            S_ADDR:      if (byte_done) state_nxt = addr_hit ? S_ADDR_ACK : S_WAIT_STOP;
            S_ADDR_ACK:  if (scl_fall && ack_drv) state_nxt = rw ? S_RDATA : S_REG;
            S_REG:       if (byte_done) state_nxt = S_REG_ACK;
            S_REG_ACK:   if (scl_fall && ack_drv) state_nxt = S_WDATA;
            S_WDATA:     if (byte_done) state_nxt = S_WDATA_ACK;
            S_WDATA_ACK: if (scl_fall && ack_drv) state_nxt = S_WDATA;
            S_RDATA:     if (scl_fall && bit_cnt == 4'd8) state_nxt = S_RDATA_ACK;
            S_RDATA_ACK: if (scl_fall && bit_cnt == 4'd9) state_nxt = nack ? S_WAIT_STOP : S_RDATA;
            default:     state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge clk_ref or negedge reset_n) begin
      if (!reset_n) begin
         ptr      <= '0;
         shreg    <= '0;
         bit_cnt  <= '0;
         ack_drv  <= 1'b0;
         rw       <= 1'b0;
         nack     <= 1'b0;
         busy     <= 1'b0;
         wr_valid <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
      end else begin
         wr_valid <= 1'b0;
         if (stop_det) begin
            ack_drv <= 1'b0;
            busy    <= 1'b0;
            bit_cnt <= '0;
         end else if (start_det) begin
            ack_drv <= 1'b0;
            bit_cnt <= '0;
         end else begin
            case (state)
               S_ADDR, S_REG, S_WDATA: if (scl_rise) begin
                  shreg   <= rx_byte;
                  bit_cnt <= byte_done ? 4'd0 : bit_cnt + 4'd1;
                  if (byte_done) begin
                     if (state == S_ADDR) begin
                        busy <= addr_hit;
                        rw   <= rx_byte[0];
                     end else if (state == S_REG) begin
                        ptr <= rx_byte[REG_AW-1:0];
                     end else begin
                        regs[ptr] <= rx_byte;
                        wr_valid  <= 1'b1;
                        wr_addr   <= ptr;
                        wr_data   <= rx_byte;
                        ptr       <= ptr_adv;
                     end
                  end
               end
               // First falling edge starts the ACK, the second ends it.
               S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: if (scl_fall) begin
                  ack_drv <= ~ack_drv;
                  if (ack_drv) shreg <= regs[ptr];
               end
               S_RDATA: begin
                  if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
                  else if (scl_fall && bit_cnt != 4'd8) shreg <= {shreg[6:0], 1'b0};
               end
               S_RDATA_ACK: begin
                  if (scl_rise) begin
                     nack    <= sda_s2;
                     bit_cnt <= 4'd9;
                  end else if (scl_fall && bit_cnt == 4'd9) begin
                     bit_cnt <= '0;
                     if (nack) busy <= 1'b0;
                     else begin
                        ptr   <= ptr_adv;
                        shreg <= regs[ptr_adv];
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_i2c_reg_target.sv
// tb/tb_i2c_reg_target.sv - Self-checking bench for i2c_reg_target driving an I2C initiator.
module tb_i2c_reg_target;
`ifdef I2C_TARGET_AUTO_INC_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       m_scl = 1'b1;
   logic       m_sda_low = 1'b0;
   logic [3:0] rd_addr = '0;
   logic       wr_valid, busy;
   logic [3:0] wr_addr;
   logic [7:0] wr_data, rd_data;
   wire        sda;

   pullup (sda);
   assign sda = m_sda_low ? 1'b0 : 1'bz;

   i2c_reg_target #(.DEV_ADDR(7'h39), .REG_AW(4)) dut (
      .clk_ref(clk), .reset_n(reset_n), .i2c_scl(m_scl), .i2c_sda(sda),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
   );

   always #5 clk = ~clk;

   int          n_err = 0, n_chk = 0, dut_drv = 0;
   logic [7:0]  mregs [16];
   logic [3:0]  mptr;
   logic [11:0] exp_q[$], act_q[$];
   logic [7:0]  wbuf[$];

   always @(negedge clk) begin
      if (reset_n && wr_valid) act_q.push_back({wr_addr, wr_data});
      if (sda === 1'b0 && !m_sda_low) dut_drv++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic q();
      repeat (6) @(negedge clk);
   endtask

   task automatic bit_xfer(input logic drv, output logic smp);
      q(); m_sda_low = ~drv;
      q(); m_scl = 1'b1;
      q(); smp = sda;
      q(); m_scl = 1'b0;
   endtask

   task automatic start();
      q(); m_sda_low = 1'b0;
      q(); m_scl = 1'b1;
      q(); m_sda_low = 1'b1;
      q(); m_scl = 1'b0;
   endtask

   task automatic stop();
      q(); m_sda_low = 1'b1;
      q(); m_scl = 1'b1;
      q(); m_sda_low = 1'b0;
      q();
   endtask

   task automatic tx(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
      bit_xfer(1'b1, s);
      ack = ~s;
   endtask

   task automatic rx(input logic ack, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, s);
         b[i] = s;
      end
      bit_xfer(~ack, s);
   endtask

   task automatic m_commit(input logic [7:0] d);
      mregs[mptr] = d;
      exp_q.push_back({mptr, d});
      if (AUTO) mptr = mptr + 1'b1;
   endtask

   task automatic m_reset();
      for (int i = 0; i < 16; i++) mregs[i] = '0;
      mptr = '0;
   endtask

   task automatic check_wr(input string nm);
      chk({nm, "_count"}, act_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) chk(nm, act_q[i], exp_q[i]);
      act_q.delete();
      exp_q.delete();
   endtask

   task automatic check_regs(input string nm);
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i);
         #1;
         chk(nm, rd_data, mregs[i]);
      end
   endtask

   task automatic do_write(input logic [7:0] reg_b, input string nm);
      logic a;
      start();
      tx(8'h72, a); chk({nm, "_addr_ack"}, a, 1'b1);
      tx(reg_b, a); chk({nm, "_reg_ack"}, a, 1'b1);
      mptr = reg_b[3:0];
      foreach (wbuf[k]) begin
         tx(wbuf[k], a); chk({nm, "_data_ack"}, a, 1'b1);
         m_commit(wbuf[k]);
      end
      stop();
      check_wr(nm);
      wbuf.delete();
   endtask

   task automatic do_read(input bit set_ptr, input logic [7:0] reg_b, input int n, input string nm);
      logic a;
      logic [7:0] b;
      start();
      if (set_ptr) begin
         tx(8'h72, a); chk({nm, "_waddr_ack"}, a, 1'b1);
         tx(reg_b, a); chk({nm, "_reg_ack"}, a, 1'b1);
         mptr = reg_b[3:0];
         start();
      end
      tx(8'h73, a); chk({nm, "_raddr_ack"}, a, 1'b1);
      for (int k = 0; k < n; k++) begin
         a = (k < n - 1);
         rx(a, b);
         chk({nm, "_byte"}, b, mregs[mptr]);
         if (a && AUTO) mptr = mptr + 1'b1;
      end
      repeat (5) @(negedge clk);
      chk({nm, "_busy_after_nack"}, busy, 1'b0);
      stop();
   endtask

   typedef struct {
      logic [7:0] addr_b;
      logic [7:0] reg_b;
      logic [7:0] data;
      logic       exp_ack;
      logic [3:0] exp_idx;
   } vec_t;
   vec_t vec [6];

   initial begin
      logic       a;
      logic [7:0] b0, b1;
      int         drv0, kind, n;

      vec[0] = '{8'h72, 8'h0A, 8'h5C, 1'b1, 4'hA};
      vec[1] = '{8'h74, 8'h01, 8'hFF, 1'b0, 4'h1};
      vec[2] = '{8'h72, 8'h15, 8'hA5, 1'b1, 4'h5};
      vec[3] = '{8'h38, 8'h02, 8'h11, 1'b0, 4'h2};
      vec[4] = '{8'h72, 8'hF0, 8'h3C, 1'b1, 4'h0};
      vec[5] = '{8'h72, 8'h0A, 8'hC3, 1'b1, 4'hA};

      m_reset();
      repeat (5) @(negedge clk);
      chk("reset_wr_valid", wr_valid, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_sda", sda, 1'b1);
      check_regs("reset_regs");
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         drv0 = dut_drv;
         start();
         tx(vec[i].addr_b, a); chk("tbl_addr_ack", a, vec[i].exp_ack);
         chk("tbl_busy", busy, vec[i].exp_ack);
         tx(vec[i].reg_b, a);  chk("tbl_reg_ack", a, vec[i].exp_ack);
         tx(vec[i].data, a);   chk("tbl_data_ack", a, vec[i].exp_ack);
         stop();
         if (vec[i].exp_ack) begin
            mptr = vec[i].reg_b[3:0];
            m_commit(vec[i].data);
         end
         check_wr("tbl_wr");
         rd_addr = vec[i].exp_idx;
         #1;
         chk("tbl_rd", rd_data, vec[i].exp_ack ? vec[i].data : mregs[vec[i].exp_idx]);
         if (!vec[i].exp_ack) chk("tbl_no_drive", dut_drv - drv0, 0);
         chk("tbl_busy_end", busy, 1'b0);
      end

      // Pointer wrap at the top of the register file.
      wbuf.push_back(8'h11);
      wbuf.push_back(8'h22);
      do_write(8'h0F, "wrap");
      rd_addr = 4'hF;
      #1;
      chk("wrap_reg_f", rd_data, AUTO ? 8'h11 : 8'h22);
      check_regs("wrap_regs");

      // Repeated-START read of two bytes, ACK then NACK.
      wbuf.push_back(8'hA3);
      do_write(8'h03, "setup3");
      wbuf.push_back(8'hB4);
      do_write(8'h04, "setup4");
      start();
      tx(8'h72, a); chk("rs_waddr_ack", a, 1'b1);
      tx(8'h03, a); chk("rs_reg_ack", a, 1'b1);
      start();
      tx(8'h73, a); chk("rs_raddr_ack", a, 1'b1);
      rx(1'b1, b0);
      rx(1'b0, b1);
      chk("rs_byte0", b0, 8'hA3);
      chk("rs_byte1", b1, AUTO ? 8'hB4 : 8'hA3);
      mptr = AUTO ? 4'h4 : 4'h3;
      repeat (5) @(negedge clk);
      chk("rs_busy_wait_stop", busy, 1'b0);
      tx(8'h72, a); chk("rs_wait_stop_no_ack", a, 1'b0);
      stop();
      chk("rs_sda_idle", sda, 1'b1);

      // Reset pulsed while the target is ACKing a data byte.
      start();
      tx(8'h72, a);
      tx(8'h02, a);
      mptr = 4'h2;
      for (int i = 7; i >= 0; i--) bit_xfer(b0[i] ^ 1'b1, a);
      m_commit(b0 ^ 8'hFF);
      q(); m_sda_low = 1'b0;
      q(); m_scl = 1'b1;
      q();
      chk("rst_ack_driven", sda, 1'b0);
      check_wr("rst_commit");
      reset_n = 1'b0;
      #1;
      chk("rst_sda_released", sda, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_wr_valid", wr_valid, 1'b0);
      m_reset();
      check_regs("rst_regs");
      @(negedge clk);
      reset_n = 1'b1;
      q(); m_scl = 1'b0;
      stop();
      wbuf.push_back(8'h3C);
      do_write(8'h05, "post_rst");
      check_regs("post_rst_regs");

      // STOP in the middle of a data byte.
      start();
      tx(8'h72, a);
      tx(8'h06, a);
      mptr = 4'h6;
      bit_xfer(1'b1, a);
      bit_xfer(1'b0, a);
      bit_xfer(1'b1, a);
      bit_xfer(1'b1, a);
      stop();
      check_wr("partial_wr");
      chk("partial_busy", busy, 1'b0);
      chk("partial_sda", sda, 1'b1);
      q(); m_scl = 1'b0;
      tx(8'h72, a); chk("partial_idle_no_ack", a, 1'b0);
      stop();
      check_regs("partial_regs");

      for (int t = 0; t < 16; t++) begin
         kind = $urandom_range(0, 2);
         if (kind == 0) begin
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) wbuf.push_back(8'($urandom));
            do_write(8'($urandom), "rnd_wr");
         end else begin
            do_read(kind == 1, 8'($urandom), $urandom_range(1, 3), "rnd_rd");
         end
         check_regs("rnd_regs");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
